// File: rtl/timer_display.sv
// Time-multiplexes BCD timer and score digits onto a 4-digit active-low seven-segment display.
// Latency: seg/dp/an are registered, one cycle behind the idx/shadow/blink state.
// Backpressure: none; the scan is free-running and inputs are sampled once per frame.
module timer_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic [3:0] score_tens,
    input  logic [3:0] score_ones,
    input  logic       pause,
    input  logic       end_game,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic          scan_tc;
    logic          frame_wrap;

    logic [3:0]    sh_sec_tens, sh_sec_ones, sh_score_tens, sh_score_ones;
    logic          sh_pause, sh_end_game;

    logic [BW-1:0] blink_cnt;
    logic          blink;
    logic          blink_tc;
    logic          blink_clr;

    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [3:0]    an_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign scan_tc    = (scan_cnt == SW'(SCAN_DIV - 1));
    assign frame_wrap = scan_tc && (idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_tc) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Shadows load on the same edge idx wraps to 0, so a frame never mixes old and new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_sec_tens   <= '0;
            sh_sec_ones   <= '0;
            sh_score_tens <= '0;
            sh_score_ones <= '0;
            sh_pause      <= 1'b0;
            sh_end_game   <= 1'b0;
        end else if (frame_wrap) begin
            sh_sec_tens   <= sec_tens;
            sh_sec_ones   <= sec_ones;
            sh_score_tens <= score_tens;
            sh_score_ones <= score_ones;
            sh_pause      <= pause;
            sh_end_game   <= end_game;
        end
    end

    // Clear at the boundary that drops pause/end_game so the display is visible immediately.
    assign blink_tc  = (blink_cnt == BW'(BLINK_DIV - 1));
    assign blink_clr = !(sh_pause || sh_end_game) || (frame_wrap && !(pause || end_game));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_clr) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_tc) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx)
            2'd3:    digit = sh_sec_tens;
            2'd2:    digit = sh_sec_ones;
            2'd1:    digit = sh_score_tens;
            default: digit = sh_score_ones;
        endcase
        blank = (sh_end_game && blink)
             || (!sh_end_game && sh_pause && blink && idx[1])
             || ((idx == 2'd1) && (sh_score_tens == 4'd0));
        seg_nxt = blank ? 7'b1111111 : decode(digit);
        dp_nxt  = !((idx == 2'd2) && !blank);
        an_nxt  = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 7'b1111111;
            dp  <= 1'b1;
            an  <= 4'b1111;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_timer_display.sv
// Bench for timer_display: two instances (4/8 and 1/3 dividers) checked against a cycle-count model.
module tb_timer_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sec_tens, sec_ones, score_tens, score_ones;
    logic       pause, end_game;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1;
    logic [3:0] an0, an1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_display #(.SCAN_DIV(4), .BLINK_DIV(8)) dut0 (
        .clk(clk), .rst(rst), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .score_tens(score_tens), .score_ones(score_ones), .pause(pause),
        .end_game(end_game), .seg(seg0), .dp(dp0), .an(an0)
    );

    timer_display #(.SCAN_DIV(1), .BLINK_DIV(3)) dut1 (
        .clk(clk), .rst(rst), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .score_tens(score_tens), .score_ones(score_ones), .pause(pause),
        .end_game(end_game), .seg(seg1), .dp(dp1), .an(an1)
    );

    typedef struct packed {
        logic [3:0] st, so, ct, co;
        logic       p, e;
    } shadow_t;

    typedef struct packed {
        logic [3:0]      st, so, ct, co;
        logic [3:0][6:0] segs;   // expected seg for idx 3..0
    } vec_t;

    // Model: edge count since reset, per-instance shadow and edge at which blinking started.
    int      n;
    int      sd [2] = '{4, 1};
    int      bd [2] = '{8, 3};
    shadow_t sh [2];
    int      act [2];

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [11:0] expect_out(input int idx, input shadow_t s, input bit bl);
        logic [3:0] d;
        logic       blank;
        logic [6:0] sg;
        logic [3:0] a;
        case (idx)
            3: d = s.st;
            2: d = s.so;
            1: d = s.ct;
            default: d = s.co;
        endcase
        blank = (s.e && bl) || (!s.e && s.p && bl && idx >= 2) || (idx == 1 && s.ct == 4'd0);
        sg = blank ? 7'b1111111 : seg_of(d);
        a  = ~(4'b0001 << idx);
        return {a, sg, !(idx == 2 && !blank)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, got, want, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 2; i++) begin
            sh[i]  = '0;
            act[i] = -1;
        end
    endtask

    task automatic step();
        logic [11:0] e [2];
        shadow_t     in_snap;
        for (int i = 0; i < 2; i++) begin
            int  idx = (n / sd[i]) % 4;
            bit  bl  = (act[i] >= 0) ? (((n - act[i]) / bd[i]) % 2 == 1) : 1'b0;
            e[i] = expect_out(idx, sh[i], bl);
        end
        in_snap = '{sec_tens, sec_ones, score_tens, score_ones, pause, end_game};
        @(posedge clk);
        n++;
        for (int i = 0; i < 2; i++) begin
            if (n % (4 * sd[i]) == 0) begin
                sh[i] = in_snap;
                if (!(in_snap.p || in_snap.e)) act[i] = -1;
                else if (act[i] < 0)           act[i] = n;
            end
        end
        #1;
        check("dut0_outputs", {20'd0, an0, seg0, dp0}, {20'd0, e[0]});
        check("dut1_outputs", {20'd0, an1, seg1, dp1}, {20'd0, e[1]});
    endtask

    task automatic align_frame();
        step();
        while (n % 16 != 0) step();
    endtask

    task automatic set_digits(input logic [3:0] a, b, c, d);
        sec_tens = a; sec_ones = b; score_tens = c; score_ones = d;
    endtask

    vec_t tbl [5];

    initial begin
        int blank3, bad0, blank2;

        tbl[0] = '{4'd9,  4'd5, 4'd4,  4'd2, {7'b0010000, 7'b0010010, 7'b0011001, 7'b0100100}};
        tbl[1] = '{4'd0,  4'd0, 4'd0,  4'd0, {7'b1000000, 7'b1000000, 7'b1111111, 7'b1000000}};
        tbl[2] = '{4'hA,  4'd1, 4'd0,  4'd7, {7'b0111111, 7'b1111001, 7'b1111111, 7'b1111000}};
        tbl[3] = '{4'd3,  4'd6, 4'd8,  4'hF, {7'b0110000, 7'b0000010, 7'b0000000, 7'b0111111}};
        tbl[4] = '{4'd1,  4'd2, 4'hF,  4'd0, {7'b1111001, 7'b0100100, 7'b0111111, 7'b1000000}};

        rst = 1'b1;
        set_digits(4'd7, 4'd3, 4'd1, 4'd6);
        pause = 1'b0; end_game = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_an",  {28'd0, an0},  {28'd0, 4'b1111});
        check("reset_seg", {25'd0, seg0}, {25'd0, 7'b1111111});
        check("reset_dp",  {31'd0, dp0},  {31'd0, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) step();

        // Asynchronous reset mid-scan, observed before the next edge.
        #3 rst = 1'b1;
        #1;
        check("async_rst_an0",  {28'd0, an0},  {28'd0, 4'b1111});
        check("async_rst_seg0", {25'd0, seg0}, {25'd0, 7'b1111111});
        check("async_rst_dp0",  {31'd0, dp0},  {31'd0, 1'b1});
        check("async_rst_an1",  {28'd0, an1},  {28'd0, 4'b1111});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();
        check("first_edge_an",  {28'd0, an0},  {28'd0, 4'b1110});
        check("first_edge_seg", {25'd0, seg0}, {25'd0, 7'b1000000});
        repeat (4) step();
        check("idx1_blank_an",  {28'd0, an0},  {28'd0, 4'b1101});
        check("idx1_blank_seg", {25'd0, seg0}, {25'd0, 7'b1111111});

        foreach (tbl[v]) begin
            set_digits(tbl[v].st, tbl[v].so, tbl[v].ct, tbl[v].co);
            align_frame();
            for (int k = 0; k < 16; k++) begin
                logic [3:0] want_an;
                want_an = ~(4'b0001 << (k / 4));
                step();
                check("tbl_an",  {28'd0, an0},  {28'd0, want_an});
                check("tbl_seg", {25'd0, seg0}, {25'd0, tbl[v].segs[k / 4]});
                check("tbl_dp",  {31'd0, dp0},  {31'd0, (k / 4 != 2)});
            end
        end

        // Mid-frame change of sec_ones stays hidden until the next frame.
        set_digits(4'd9, 4'd5, 4'd4, 4'd2);
        align_frame();
        repeat (5) step();
        sec_ones = 4'd4;
        repeat (4) step();
        check("coh_old_an",  {28'd0, an0},  {28'd0, 4'b1011});
        check("coh_old_seg", {25'd0, seg0}, {25'd0, 7'b0010010});
        repeat (16) step();
        check("coh_new_an",  {28'd0, an0},  {28'd0, 4'b1011});
        check("coh_new_seg", {25'd0, seg0}, {25'd0, 7'b0011001});

        pause = 1'b1;
        align_frame();
        blank3 = 0; bad0 = 0;
        for (int k = 0; k < 48; k++) begin
            step();
            if (an0 == 4'b0111 && seg0 == 7'b1111111) blank3++;
            if (an0 == 4'b1110 && seg0 != 7'b0100100) bad0++;
        end
        check("pause_timer_blanks", {31'd0, blank3 > 0}, 32'd1);
        check("pause_score_steady", bad0, 32'd0);
        pause = 1'b0;
        align_frame();
        repeat (13) step();
        check("unpause_an",  {28'd0, an0},  {28'd0, 4'b0111});
        check("unpause_seg", {25'd0, seg0}, {25'd0, 7'b0010000});

        pause = 1'b1; end_game = 1'b1;
        align_frame();
        blank2 = 0;
        for (int k = 0; k < 48; k++) begin
            step();
            if (an0 == 4'b1011 && seg0 == 7'b1111111 && dp0 == 1'b1) blank2++;
        end
        check("endgame_blank_dp", {31'd0, blank2 > 0}, 32'd1);
        pause = 1'b0; end_game = 1'b0;

        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 7) == 0)
                set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 39) == 0) begin
                pause    = 1'($urandom_range(0, 1));
                end_game = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
